// File: rtl/mem_access_ctrl_if.sv
// Processor request/response and memory-side bus bundle for mem_access_ctrl.
interface mem_access_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_reg_we;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   // Controller view
   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
      output req_ready, resp_valid, resp_data, resp_reg_we, resp_err,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   // Processor + memory view
   modport master (
      output req_valid, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
      input  req_ready, resp_valid, resp_data, resp_reg_we, resp_err,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller: lw/lb/sw/sb against a word-wide memory with
// big-endian byte lanes, read-modify-write for sb, and a per-phase timeout.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic         clk,
   input  logic         rst,
   mem_access_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [1:0]  OP_LW = 2'b00;
   localparam logic [1:0]  OP_LB = 2'b01;
   localparam logic [1:0]  OP_SW = 2'b10;
   localparam logic [1:0]  OP_SB = 2'b11;

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [1:0]         r_op;
   logic [31:0]        r_addr;
   logic [31:0]        r_wdata;
   logic [31:0]        r_rdata;
   logic               r_err;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_accept;
   logic               w_misalign;
   logic               w_in_phase;
   logic               w_phase_entry;
   logic               w_set_err;
   logic               w_timeout;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic [7:0]         w_sel_byte;
   logic [31:0]        w_merged;

   assign w_accept      = bus.req_valid && (r_state == IDLE);
   // Only word ops care about alignment; byte ops are always aligned
   assign w_misalign    = !bus.req_op[0] && (bus.req_addr[1:0] != 2'b00);
   assign w_in_phase    = (r_state == RD) || (r_state == WR);
   assign w_cnt_inc     = r_cnt + CNT_W'(1);
   assign w_timeout     = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
   assign w_phase_entry = (w_next != r_state) && ((w_next == RD) || (w_next == WR));

   // Next-state decode; a same-cycle ack beats the timeout
   always_comb begin
      w_next    = r_state;
      w_set_err = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_misalign) begin
                  w_next    = RESP;
                  w_set_err = 1'b1;
               end else if (bus.req_op == OP_SW) begin
                  w_next = WR;
               end else begin
                  w_next = RD;
               end
            end
         end
         RD: begin
            if (bus.mem_ack) begin
               w_next = (r_op == OP_SB) ? WR : RESP;
            end else if (w_timeout) begin
               w_next    = RESP;
               w_set_err = 1'b1;
            end
         end
         WR: begin
            if (bus.mem_ack) begin
               w_next = RESP;
            end else if (w_timeout) begin
               w_next    = RESP;
               w_set_err = 1'b1;
            end
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Wait counter: cleared on phase entry, counts unacknowledged phase cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                               r_cnt <= '0;
      else if (w_phase_entry)                r_cnt <= '0;
      else if (w_in_phase && !bus.mem_ack)   r_cnt <= w_cnt_inc;
   end

   // Request fields, read word and error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op    <= 2'b00;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_rdata <= 32'h0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_op    <= bus.req_op;
         r_addr  <= bus.req_addr;
         r_wdata <= bus.req_wdata;
         r_rdata <= 32'h0;
         r_err   <= w_set_err;
      end else begin
         if ((r_state == RD) && bus.mem_ack) r_rdata <= bus.mem_rdata;
         if (w_set_err)                      r_err   <= 1'b1;
      end
   end

   // Big-endian lane select for lb and lane merge for sb
   always_comb begin
      w_sel_byte = 8'h00;
      w_merged   = r_rdata;
      case (r_addr[1:0])
         2'b00: begin w_sel_byte = r_rdata[31:24]; w_merged[31:24] = r_wdata[7:0]; end
         2'b01: begin w_sel_byte = r_rdata[23:16]; w_merged[23:16] = r_wdata[7:0]; end
         2'b10: begin w_sel_byte = r_rdata[15:8];  w_merged[15:8]  = r_wdata[7:0]; end
         default: begin w_sel_byte = r_rdata[7:0]; w_merged[7:0]   = r_wdata[7:0]; end
      endcase
   end

   // Outputs decoded from registered state and fields; ready is also held low by rst
   assign bus.req_ready   = (r_state == IDLE) && !rst;
   assign bus.mem_req     = w_in_phase;
   assign bus.mem_we      = (r_state == WR);
   assign bus.mem_addr    = w_in_phase ? {r_addr[31:2], 2'b00} : 32'h0;
   assign bus.mem_wdata   = (r_state != WR) ? 32'h0 :
                            (r_op == OP_SW) ? r_wdata : w_merged;
   assign bus.resp_valid  = (r_state == RESP);
   assign bus.resp_err    = (r_state == RESP) && r_err;
   assign bus.resp_reg_we = (r_state == RESP) && !r_err && !r_op[1];
   assign bus.resp_data   = ((r_state != RESP) || r_err) ? 32'h0 :
                            (r_op == OP_LW) ? r_rdata :
                            (r_op == OP_LB) ? {r_wdata[31:8], w_sel_byte} : 32'h0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl with a transaction-level model that
// predicts every cycle of each access, plus directed literal checks.
module tb_mem_access_ctrl;
   localparam int TO = 4;

   typedef struct {
      logic        req_ready;
      logic        resp_valid;
      logic [31:0] resp_data;
      logic        resp_reg_we;
      logic        resp_err;
      logic        mem_req;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   mem_access_if bus();

   mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t exp_q[$];
   logic [31:0] mem [logic [29:0]];

   // Observations taken from the DUT for directed literal checks
   int cyc = 0, accept_cyc = 0, last_lat = 0, req_cycles = 0, resp_seen = 0;
   logic [31:0] last_data, last_wr_wdata, last_wr_addr, last_rd_addr;
   logic last_we, last_err;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, expv, $time);
      end
   endfunction

   function automatic exp_t idle_exp();
      exp_t e = '{default: '0};
      e.req_ready = 1'b1;
      return e;
   endfunction

   function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
      int sh = 8 * (3 - int'(lane));
      return 8'((w >> sh) & 32'hFF);
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] lane, input logic [7:0] b);
      int sh = 8 * (3 - int'(lane));
      return (w & ~(32'hFF << sh)) | (32'(b) << sh);
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (!mem.exists(a[31:2])) mem[a[31:2]] = $urandom;
      return mem[a[31:2]];
   endfunction

   // Per-cycle compare against the model plus observation capture
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("req_ready",   32'(bus.req_ready),   32'(e.req_ready));
         chk("resp_valid",  32'(bus.resp_valid),  32'(e.resp_valid));
         chk("resp_data",   bus.resp_data,        e.resp_data);
         chk("resp_reg_we", 32'(bus.resp_reg_we), 32'(e.resp_reg_we));
         chk("resp_err",    32'(bus.resp_err),    32'(e.resp_err));
         chk("mem_req",     32'(bus.mem_req),     32'(e.mem_req));
         chk("mem_we",      32'(bus.mem_we),      32'(e.mem_we));
         chk("mem_addr",    bus.mem_addr,         e.mem_addr);
         chk("mem_wdata",   bus.mem_wdata,        e.mem_wdata);
      end
      if (bus.req_valid && bus.req_ready) begin accept_cyc = cyc; req_cycles = 0; end
      if (bus.mem_req) req_cycles++;
      if (bus.mem_req && bus.mem_we) begin last_wr_wdata = bus.mem_wdata; last_wr_addr = bus.mem_addr; end
      if (bus.mem_req && !bus.mem_we) last_rd_addr = bus.mem_addr;
      if (bus.resp_valid) begin
         resp_seen++;
         last_lat  = cyc - accept_cyc;
         last_data = bus.resp_data;
         last_we   = bus.resp_reg_we;
         last_err  = bus.resp_err;
      end
   end

   task automatic noise_req();
      bus.req_valid = 1'($urandom);
      bus.req_op    = 2'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.req_valid = 1'b0;
         bus.mem_ack   = 1'($urandom);
         bus.mem_rdata = $urandom;
         exp_q.push_back(idle_exp());
      end
   endtask

   // One memory phase acked on cycle d+1, or never when d >= TO
   task automatic phase(input logic we, input logic [31:0] a, input logic [31:0] wword,
                        input int d, input logic [31:0] rword, output bit acked);
      exp_t e;
      int n = (d < TO) ? d + 1 : TO;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         noise_req();
         bus.mem_ack   = (d < TO) && (k == d + 1);
         bus.mem_rdata = (bus.mem_ack && !we) ? rword : $urandom;
         e = '{default: '0};
         e.mem_req   = 1'b1;
         e.mem_we    = we;
         e.mem_addr  = {a[31:2], 2'b00};
         e.mem_wdata = we ? wword : 32'h0;
         exp_q.push_back(e);
      end
      acked = (d < TO);
   endtask

   task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input int d_rd, input int d_wr);
      exp_t e;
      bit misal, err, acked;
      logic [31:0] rword, wword;
      misal = !op[0] && (a[1:0] != 2'b00);
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_wdata = wd;
      bus.mem_ack = 1'($urandom); bus.mem_rdata = $urandom;
      exp_q.push_back(idle_exp());
      err = misal; rword = 32'h0;
      if (!misal) begin
         if (op != 2'b10) begin
            rword = mem_rd(a);
            phase(1'b0, a, 32'h0, d_rd, rword, acked);
            if (!acked) err = 1'b1;
         end
         if (!err && op[1]) begin
            wword = (op == 2'b10) ? wd : lane_merge(rword, a[1:0], wd[7:0]);
            phase(1'b1, a, wword, d_wr, 32'h0, acked);
            if (acked) mem[a[31:2]] = wword;
            else       err = 1'b1;
         end
      end
      @(posedge clk); #1;
      noise_req();
      bus.mem_ack = 1'($urandom); bus.mem_rdata = $urandom;
      e = '{default: '0};
      e.resp_valid  = 1'b1;
      e.resp_err    = err;
      e.resp_reg_we = !err && !op[1];
      e.resp_data   = err ? 32'h0 :
                      (op == 2'b00) ? rword :
                      (op == 2'b01) ? {wd[31:8], lane_byte(rword, a[1:0])} : 32'h0;
      exp_q.push_back(e);
   endtask

   initial begin
      int resp_before;
      bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;

      // Reset state: everything low including req_ready
      #2;
      chk("rst_ready",   32'(bus.req_ready),  32'h0);
      chk("rst_mem_req", 32'(bus.mem_req),    32'h0);
      chk("rst_valid",   32'(bus.resp_valid), 32'h0);
      chk("rst_addr",    bus.mem_addr,        32'h0);
      #20 rst = 1'b0;
      #1 chk("post_rst_ready", 32'(bus.req_ready), 32'h1);

      // Directed: lw
      mem[30'(32'h100 >> 2)] = 32'hDEADBEEF;
      run_txn(2'b00, 32'h100, $urandom, 0, 0);
      idle_cycles(1);
      chk("lw_lat", 32'(last_lat), 32'd2);
      chk("lw_data", last_data, 32'hDEADBEEF);
      chk("lw_we", 32'(last_we), 32'h1);
      chk("lw_addr", last_rd_addr, 32'h100);

      // Directed: lb lane 10
      mem[30'(32'h100 >> 2)] = 32'hAABBCCDD;
      run_txn(2'b01, 32'h102, 32'h11223344, 0, 0);
      idle_cycles(1);
      chk("lb_data", last_data, 32'h112233CC);
      chk("lb_we", 32'(last_we), 32'h1);

      // Directed: sb read-modify-write
      mem[30'(32'h200 >> 2)] = 32'h01020304;
      run_txn(2'b11, 32'h203, 32'h000000EE, 0, 0);
      idle_cycles(1);
      chk("sb_wdata", last_wr_wdata, 32'h010203EE);
      chk("sb_waddr", last_wr_addr, 32'h200);
      chk("sb_lat", 32'(last_lat), 32'd3);
      chk("sb_we", 32'(last_we), 32'h0);

      // Directed: misaligned sw
      run_txn(2'b10, 32'h101, $urandom, 0, 0);
      idle_cycles(1);
      chk("mis_lat", 32'(last_lat), 32'd1);
      chk("mis_err", 32'(last_err), 32'h1);
      chk("mis_req_cycles", 32'(req_cycles), 32'd0);

      // Directed: timeout, then ack on the last allowed cycle
      run_txn(2'b00, 32'h400, $urandom, 99, 0);
      idle_cycles(1);
      chk("to_req_cycles", 32'(req_cycles), 32'd4);
      chk("to_err", 32'(last_err), 32'h1);
      chk("to_data", last_data, 32'h0);
      run_txn(2'b00, 32'h400, $urandom, 3, 0);
      idle_cycles(1);
      chk("late_req_cycles", 32'(req_cycles), 32'd4);
      chk("late_err", 32'(last_err), 32'h0);

      // Randomized traffic
      for (int t = 0; t < 300; t++) begin
         logic [1:0] op = 2'($urandom);
         logic [31:0] a = 32'h1000 + $urandom_range(0, 63);
         int d_rd = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(0, 5);
         int d_wr = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(0, 5);
         run_txn(op, a, $urandom, d_rd, d_wr);
         idle_cycles($urandom_range(1, 3));
      end

      // Reset during a write phase with no ack
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_addr = 32'h300; bus.req_wdata = $urandom;
      bus.mem_ack = 1'b0;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      chk("wr_before_rst", 32'(bus.mem_req), 32'h1);
      resp_before = resp_seen;
      #2 rst = 1'b1;
      #1;
      chk("async_mem_req", 32'(bus.mem_req), 32'h0);
      chk("async_ready",   32'(bus.req_ready), 32'h0);
      chk("async_we",      32'(bus.mem_we), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("rel_ready", 32'(bus.req_ready), 32'h1);
      mem[30'(32'h500 >> 2)] = 32'h5A5A1234;
      run_txn(2'b00, 32'h500, $urandom, 0, 0);
      idle_cycles(2);
      chk("rst_no_resp", 32'(resp_seen - resp_before), 32'd1);
      chk("rst_lw_lat", 32'(last_lat), 32'd2);
      chk("rst_lw_data", last_data, 32'h5A5A1234);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got time %0t expected below 500000", $time);
      $fatal(1);
   end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Parameters
REQ-001 The block SHALL have a parameter TIMEOUT_CYCLES, default 16: the maximum number of cycles one memory phase waits for mem_ack before aborting.

Interface
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  the processor presents a load or store request.
REQ-005 req_ready  output  1  the controller can accept a request; high only in IDLE.
REQ-006 req_op  input  2  00 lw, 01 lb, 10 sw, 11 sb.
REQ-007 req_addr  input  32  byte address, which is rs_data plus the sign-extended immediate.
REQ-008 req_wdata  input  32  rt_data: the store source, and the upper bits merged into an lb result.
REQ-009 resp_valid  output  1  one-cycle completion pulse.
REQ-010 resp_data  output  32  the load result; 0 for stores and for errors.
REQ-011 resp_reg_we  output  1  write-enable for the register file; qualified by resp_valid.
REQ-012 resp_err  output  1  misalignment or timeout; qualified by resp_valid.
REQ-013 mem_req  output  1  memory access request, held until acknowledged.
REQ-014 mem_we  output  1  1 = write phase, 0 = read phase.
REQ-015 mem_addr  output  32  word address: {addr[31:2], 2'b00}.
REQ-016 mem_wdata  output  32  the word to write.
REQ-017 mem_ack  input  1  memory completes the current phase in the cycle it is sampled high.
REQ-018 mem_rdata  input  32  read word; valid in the cycle mem_ack is high during a read phase.

Function
REQ-019 States SHALL be IDLE, RD, WR and RESP, and the state SHALL be held in a registered state variable.
REQ-020 In IDLE, req_valid&&req_ready SHALL latch op, addr and wdata.
- lw or sw with addr[1:0]!=0 goes to RESP with the error flag set.
- lw, lb or sb goes to RD.
- sw goes to WR.
REQ-021 In RD, mem_req=1 and mem_we=0; the block SHALL stay in RD until mem_ack, then capture mem_rdata.
- lw or lb then goes to RESP.
- sb then goes to WR.
REQ-022 In WR, mem_req=1 and mem_we=1; the block SHALL stay in WR until mem_ack, then go to RESP.
REQ-023 mem_wdata SHALL be as follows.
- For sw: wdata.
- For sb: the captured word with the byte lane selected by addr[1:0] replaced by wdata[7:0].
- Byte lanes are big-endian: 00 maps to bits [31:24], 01 to [23:16], 10 to [15:8], 11 to [7:0].
REQ-024 mem_addr and mem_wdata SHALL stay stable while mem_req is high; mem_req, mem_addr and mem_wdata SHALL be 0 outside RD and WR.
REQ-025 RESP SHALL assert resp_valid for exactly one cycle and then return to IDLE; no new request is accepted in RESP.
REQ-026 resp_data SHALL be as follows.
- lw: the captured word.
- lb: {wdata[31:8], selected byte} using the REQ-023 lane map.
- sw or sb: 0.
- Any error: 0.
REQ-027 resp_reg_we SHALL be 1 in RESP only for lw or lb without error; resp_err SHALL be 1 in RESP only on error.
REQ-028 A wait counter SHALL clear on every entry to RD or WR and increment in each RD or WR cycle without mem_ack.
- On reaching TIMEOUT_CYCLES, the block SHALL drop mem_req, go to RESP and set the error flag.
- An sb that times out in RD SHALL NOT issue its write.
REQ-029 mem_ack sampled while mem_req=0 SHALL be ignored.
REQ-030 mem_ack in the same cycle that the counter reaches TIMEOUT_CYCLES SHALL win: the phase completes normally.
REQ-031 Latency from the acceptance cycle to resp_valid, with mem_ack asserted in the first cycle of each phase, SHALL be:
- lw, lb and sw: 2 cycles.
- sb: 3 cycles.
- misaligned lw or sw: 1 cycle.

Reset
REQ-032 While rst=1, the block SHALL be in IDLE and every output SHALL be 0, including req_ready; rst=1 SHALL take effect asynchronously.
REQ-033 Reset mid-operation SHALL abandon the access: mem_req drops immediately and no resp_valid is produced for the abandoned request.
REQ-034 In the first cycle after rst falls, req_ready=1; the wait counter and all latched fields SHALL be 0 after reset.

Verification
REQ-035 lw: addr=0x100 with mem_ack on the first RD cycle and mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, then 2 cycles after acceptance resp_valid=1, resp_data=0xDEADBEEF, resp_reg_we=1, resp_err=0.
REQ-036 lb: addr=0x102, wdata=0x11223344, mem_rdata=0xAABBCCDD -> resp_data=0x112233CC, resp_reg_we=1.
REQ-037 sb: addr=0x203, wdata=0x000000EE, read returns 0x01020304 -> the next phase writes mem_addr=0x200, mem_wdata=0x010203EE, mem_we=1; resp_valid 3 cycles after acceptance with resp_reg_we=0.
REQ-038 Misaligned sw with addr=0x101 -> mem_req never asserts; resp_valid and resp_err=1 one cycle after acceptance.
REQ-039 Timeout: mem_ack held low with TIMEOUT_CYCLES=4 -> mem_req high for exactly 4 cycles, then resp_err=1 and resp_data=0; ack arriving on the 4th cycle completes normally with resp_err=0.
REQ-040 Reset asserted in WR with mem_ack low -> mem_req=0 asynchronously, no resp_valid; after release a new lw completes with 2-cycle latency.
